// File: rtl/step_ctrl_pkg.sv
// Shared types and default opcode constants for the step-enable controller
// and the control-unit decoder.
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN          = 2'b00,
    WAIT_PRESS   = 2'b01,
    WAIT_RELEASE = 2'b10
  } state_t;

  localparam logic [5:0] OP_IN  = 6'b011101;
  localparam logic [5:0] OP_OUT = 6'b100000;
  localparam logic [5:0] OP_HLT = 6'b011100;

endpackage

// File: rtl/button_debouncer.sv
// Synchronises the raw step button and accepts a level change only after it
// has been stable for DEBOUNCE_CYCLES samples; emits a strobe on a new press.
module button_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   w_synced;
  logic                   w_differs;
  logic                   w_settled;

  assign w_synced  = r_sync[SYNC_STAGES-1];
  assign w_differs = (w_synced != r_level);
  assign w_settled = w_differs && (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
      // Strobe is registered together with the level so both appear in the same cycle
      r_rise <= w_settled && !r_level;
      if (w_settled) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else if (w_differs) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;

endmodule

// File: rtl/step_enable_controller.sv
// Produces the CPU clock-enable pulse: free-running divider in normal
// operation, one pulse per debounced button press for step-type opcodes.
module step_enable_controller #(
  parameter int                      OPCODE_WIDTH    = 6,
  parameter logic [OPCODE_WIDTH-1:0] OP_IN           = OPCODE_WIDTH'(step_ctrl_pkg::OP_IN),
  parameter logic [OPCODE_WIDTH-1:0] OP_OUT          = OPCODE_WIDTH'(step_ctrl_pkg::OP_OUT),
  parameter logic [OPCODE_WIDTH-1:0] OP_HLT          = OPCODE_WIDTH'(step_ctrl_pkg::OP_HLT),
  parameter int                      CLOCK_DIV       = 4,
  parameter int                      SYNC_STAGES     = 2,
  parameter int                      DEBOUNCE_CYCLES = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [OPCODE_WIDTH-1:0] operation,
  input  logic                    stepMode,
  input  logic                    stepButton,
  output logic                    cpuEnable,
  output logic                    waitingStep,
  output logic                    buttonLevel
);

  import step_ctrl_pkg::*;

  localparam int DIV_W = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;

  state_t           r_state;
  state_t           w_next_state;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_next_div;
  logic             w_step_op;
  logic             w_terminal;
  logic             w_enable;
  logic             w_waiting;
  logic             w_level;
  logic             w_rise;

  button_debouncer #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clock(clock),
    .reset(reset),
    .raw  (stepButton),
    .level(w_level),
    .rise (w_rise)
  );

  assign w_step_op  = (operation == OP_IN) || (operation == OP_OUT) ||
                      (operation == OP_HLT) || stepMode;
  assign w_terminal = (r_div == DIV_W'(CLOCK_DIV - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
      r_div   <= '0;
    end else begin
      r_state <= w_next_state;
      r_div   <= w_next_div;
    end
  end

  // The divider only advances in RUN; both wait states park it at zero.
  always_comb begin
    w_next_state = r_state;
    w_next_div   = '0;
    w_enable     = 1'b0;
    w_waiting    = 1'b0;
    case (r_state)
      RUN: begin
        if (w_terminal) begin
          if (w_step_op) begin
            w_next_state = WAIT_PRESS;
          end else begin
            w_enable = 1'b1;
          end
        end else begin
          w_next_div = r_div + DIV_W'(1);
        end
      end
      WAIT_PRESS: begin
        w_waiting = 1'b1;
        if (w_rise) begin
          w_enable     = 1'b1;
          w_next_state = WAIT_RELEASE;
        end
      end
      WAIT_RELEASE: begin
        if (!w_level) begin
          w_next_state = RUN;
        end
      end
      default: begin
        w_next_state = RUN;
      end
    endcase
  end

  // Gating with reset keeps the outputs quiet during reset even when every cycle is terminal.
  assign cpuEnable   = reset && w_enable;
  assign waitingStep = reset && w_waiting;
  assign buttonLevel = w_level;

endmodule

// File: tb/tb_step_enable_controller.sv
// Self-checking bench for step_enable_controller: directed scenarios with
// literal expectations plus randomized stimulus against a behavioural model.
module tb_step_enable_controller;

  localparam int         CLOCK_DIV = 4;
  localparam int         SYNC      = 2;
  localparam int         DEB       = 16;
  localparam logic [5:0] T_OP_IN   = 6'b011101;
  localparam logic [5:0] T_OP_OUT  = 6'b100000;
  localparam logic [5:0] T_OP_HLT  = 6'b011100;
  localparam logic [5:0] T_OP_ADD  = 6'b000001;
  localparam int         M_RUN     = 0;
  localparam int         M_WAITP   = 1;
  localparam int         M_WAITR   = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] operation = 6'd0;
  logic       stepMode = 1'b0;
  logic       stepButton = 1'b0;
  logic       cpuEnable;
  logic       waitingStep;
  logic       buttonLevel;

  int n_checks = 0;
  int n_fail   = 0;

  step_enable_controller #(
    .OPCODE_WIDTH   (6),
    .OP_IN          (T_OP_IN),
    .OP_OUT         (T_OP_OUT),
    .OP_HLT         (T_OP_HLT),
    .CLOCK_DIV      (CLOCK_DIV),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .operation  (operation),
    .stepMode   (stepMode),
    .stepButton (stepButton),
    .cpuEnable  (cpuEnable),
    .waitingStep(waitingStep),
    .buttonLevel(buttonLevel)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit step_op(input logic [5:0] op, input logic sm);
    return (op == T_OP_IN) || (op == T_OP_OUT) || (op == T_OP_HLT) || sm;
  endfunction

  // Behavioural model: mode, position within the divide period, debounced view
  int   m_mode  = M_RUN;
  int   m_phase = 0;
  int   m_run   = 0;
  logic m_level = 1'b0;
  logic m_rise  = 1'b0;
  logic sync_q[$];

  initial begin
    logic synced;
    forever begin
      @(posedge clock or negedge reset);
      if (!reset) begin
        m_mode  = M_RUN;
        m_phase = 0;
        m_run   = 0;
        m_level = 1'b0;
        m_rise  = 1'b0;
        sync_q.delete();
        for (int i = 0; i < SYNC; i++) sync_q.push_back(1'b0);
      end else begin
        if (m_mode == M_RUN) begin
          if (m_phase == CLOCK_DIV - 1) begin
            m_phase = 0;
            if (step_op(operation, stepMode)) m_mode = M_WAITP;
          end else begin
            m_phase = m_phase + 1;
          end
        end else if (m_mode == M_WAITP) begin
          if (m_rise) m_mode = M_WAITR;
        end else if (!m_level) begin
          m_mode  = M_RUN;
          m_phase = 0;
        end
        synced = sync_q.pop_front();
        sync_q.push_back(stepButton);
        m_rise = 1'b0;
        if (synced != m_level) begin
          m_run = m_run + 1;
          if (m_run == DEB) begin
            m_level = ~m_level;
            m_run   = 0;
            m_rise  = m_level;
          end
        end else begin
          m_run = 0;
        end
      end
    end
  end

  initial begin
    logic exp_en, exp_wait, prev_en;
    prev_en = 1'b0;
    forever begin
      @(negedge clock);
      exp_wait = reset && (m_mode == M_WAITP);
      exp_en   = reset && (((m_mode == M_RUN) && (m_phase == CLOCK_DIV - 1) &&
                            !step_op(operation, stepMode)) ||
                           ((m_mode == M_WAITP) && m_rise));
      check("cpuEnable", cpuEnable, exp_en);
      check("waitingStep", waitingStep, exp_wait);
      check("buttonLevel", buttonLevel, m_level);
      check("no_double_pulse", cpuEnable && prev_en, 0);
      prev_en = cpuEnable;
    end
  end

  task automatic run_cycles(input int n, output int pulses, output int first_at,
                            output logic saw_level, output logic [63:0] mask);
    pulses = 0; first_at = -1; saw_level = 1'b0; mask = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (cpuEnable) begin
        if (first_at < 0) first_at = i;
        pulses++;
        if (i < 64) mask[i] = 1'b1;
      end
      if (buttonLevel) saw_level = 1'b1;
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    int p, f, total;
    logic lv, any_lv;
    logic [63:0] mk;
    int hold;

    stepButton = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_cpuEnable", cpuEnable, 0);
    check("reset_waitingStep", waitingStep, 0);
    check("reset_buttonLevel", buttonLevel, 0);
    @(posedge clock); #1;
    stepButton = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;

    // Free-running divide by 4
    run_cycles(12, p, f, lv, mk);
    check("auto_pulse_mask", mk, 64'h888);

    // IN at terminal count, then one held press
    operation = T_OP_IN;
    run_cycles(4, p, f, lv, mk);
    check("in_no_pulse", p, 0);
    run_cycles(1, p, f, lv, mk);
    check("in_waiting_next", waitingStep, 1);
    stepButton = 1'b1;
    run_cycles(40, p, f, lv, mk);
    check("press_pulses", p, 1);
    check("press_latency", f, DEB + SYNC);
    stepButton = 1'b0;
    operation  = 6'd0;
    run_cycles(30, p, f, lv, mk);
    check("resume_latency", f, DEB + SYNC + CLOCK_DIV);

    // Short glitches while waiting
    stepMode = 1'b1;
    operation = T_OP_ADD;
    run_cycles(8, p, f, lv, mk);
    check("stepmode_no_auto", p, 0);
    total = 0; any_lv = 1'b0;
    for (int r = 0; r < 6; r++) begin
      stepButton = 1'b1;
      run_cycles(5, p, f, lv, mk);
      total += p; any_lv |= lv;
      stepButton = 1'b0;
      run_cycles(5, p, f, lv, mk);
      total += p; any_lv |= lv;
    end
    check("glitch_pulses", total, 0);
    check("glitch_level", any_lv, 0);
    check("glitch_still_waiting", waitingStep, 1);

    // Three step presses in step mode
    total = 0;
    for (int r = 0; r < 3; r++) begin
      stepButton = 1'b1;
      run_cycles(30, p, f, lv, mk);
      total += p;
      stepButton = 1'b0;
      run_cycles(30, p, f, lv, mk);
      total += p;
    end
    check("stepmode_three_pulses", total, 3);

    // HLT entered with the button already held
    stepMode = 1'b0;
    operation = 6'd0;
    stepButton = 1'b1;
    run_cycles(25, p, f, lv, mk);
    operation = T_OP_HLT;
    run_cycles(30, p, f, lv, mk);
    check("hlt_held_no_pulse", p, 0);
    stepButton = 1'b0;
    run_cycles(30, p, f, lv, mk);
    check("hlt_release_no_pulse", p, 0);
    stepButton = 1'b1;
    run_cycles(30, p, f, lv, mk);
    check("hlt_new_press_pulse", p, 1);
    stepButton = 1'b0;
    run_cycles(30, p, f, lv, mk);

    // Asynchronous reset in WAIT_PRESS
    @(negedge clock);
    check("pre_reset_waiting", waitingStep, 1);
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    check("async_reset_waiting", waitingStep, 0);
    check("async_reset_enable", cpuEnable, 0);
    operation = 6'd0;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    run_cycles(8, p, f, lv, mk);
    check("post_reset_mask", mk, 64'h88);

    // Randomized traffic
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        stepButton = 1'($urandom_range(0, 1));
        hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : $urandom_range(15, 45);
      end
      hold--;
      if ($urandom_range(0, 19) == 0) begin
        case ($urandom_range(0, 3))
          0: operation = T_OP_IN;
          1: operation = T_OP_OUT;
          2: operation = T_OP_HLT;
          default: operation = 6'($urandom);
        endcase
      end
      if ($urandom_range(0, 49) == 0) stepMode = ~stepMode;
      if ($urandom_range(0, 999) == 0) begin
        #1 reset = 1'b0;
        #1 reset = 1'b1;
      end
      @(posedge clock);
      #1;
    end

    @(negedge clock);
    @(posedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/step_enable_controller.md
Name: step_enable_controller

Overview:
- Parametrised successor to the CPU opcode-driven clock source selector.
- Runs on the single system clock and produces a one-cycle CPU clock-enable pulse instead of muxing clock nets.
- In normal operation the enables come from a free-running divider. For IN, OUT and HLT opcodes, and for every opcode when single-step mode is on, each enable waits for a debounced press of the manual step button.
- Sits between the control unit's opcode field and the enable input of every CPU state register.

Parameters:
- OPCODE_WIDTH, 6, width of the operation field.
- OP_IN, 6'b011101, input opcode; requires a manual step.
- OP_OUT, 6'b100000, output opcode; requires a manual step.
- OP_HLT, 6'b011100, halt opcode; requires a manual step.
- CLOCK_DIV, 4, system cycles per automatic enable; legal range 1..2^16.
- SYNC_STAGES, 2, synchronizer flops on the button input; minimum 2.
- DEBOUNCE_CYCLES, 16, consecutive stable samples needed to accept a button level change; minimum 1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- operation  in  OPCODE_WIDTH  opcode of the current instruction.
- stepMode  in  1  1 = every instruction needs a button press.
- stepButton  in  1  raw, asynchronous, bouncing manual step button.
- cpuEnable  out  1  one-cycle enable pulse for the CPU registers.
- waitingStep  out  1  high while waiting for a button press.
- buttonLevel  out  1  debounced button level, for LED and debug use.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=RUN, divider=0, synchronizer and debounce counter=0, buttonLevel=0.
  - cpuEnable=0, waitingStep=0.
  - Outputs return to these values immediately if reset is asserted mid-operation.
- stepOp = (operation==OP_IN) or (operation==OP_OUT) or (operation==OP_HLT) or stepMode. It is evaluated combinationally from the current inputs.
- Debounce:
  - The button passes through SYNC_STAGES flops.
  - The counter increments while the synchronized value differs from buttonLevel, and clears to 0 when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, buttonLevel toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes buttonLevel.
  - press = buttonLevel rising edge, a one-cycle internal strobe.
- State RUN:
  - The divider counts 0..CLOCK_DIV-1 and wraps to 0.
  - At terminal count with stepOp=0: cpuEnable=1 for that cycle.
  - At terminal count with stepOp=1: no pulse; next state WAIT_PRESS.
  - With CLOCK_DIV=1 every cycle is terminal.
- State WAIT_PRESS:
  - waitingStep=1 and the divider is held at 0.
  - On press: cpuEnable=1 in the same cycle the strobe is seen; next state WAIT_RELEASE.
  - If the button is already held on entry, no pulse is issued; a new rising edge is required.
- State WAIT_RELEASE:
  - waitingStep=0, no pulses.
  - When buttonLevel==0, next state RUN with divider=0.
  - The first automatic pulse after return comes CLOCK_DIV cycles later.
- Operation changes while waiting have no effect; a pending step is never cancelled.
  - Example: if stepMode drops during WAIT_PRESS, the controller still waits for the press.
- cpuEnable never stays high for two consecutive cycles.
- At most one pulse is issued per button press.

Decomposition:
- Shared package step_ctrl_pkg holds:
  - state enum {RUN, WAIT_PRESS, WAIT_RELEASE}, encoded 2'b00/01/10;
  - default opcode constants OP_IN, OP_OUT and OP_HLT, reused by the control unit decoder.
- One natural sub-module: button_debouncer.
  - Parameters: SYNC_STAGES, DEBOUNCE_CYCLES.
  - Ports: clock, reset, raw, level, rise.
  - It is instanced once.
- The FSM and divider stay in the top module.

Test Plan:
1. Reset released, operation=6'b000000, stepMode=0, CLOCK_DIV=4 -> cpuEnable pulses on cycles 3, 7, 11 (one cycle each); waitingStep stays 0.
2. operation=OP_IN at divider terminal count -> no pulse, waitingStep=1 from the next cycle. Button held 40 cycles -> exactly one cpuEnable pulse DEBOUNCE_CYCLES+SYNC_STAGES cycles after the press edge. After release and debounce, automatic pulses resume 4 cycles later.
3. Button glitches of 5 high cycles repeated during WAIT_PRESS with DEBOUNCE_CYCLES=16 -> buttonLevel stays 0, no cpuEnable.
4. stepMode=1, opcode=ADD, three press/release cycles -> exactly three cpuEnable pulses and no automatic pulses.
5. OP_HLT entered while the button is already held -> no pulse until release and a new press.
6. reset driven low mid-WAIT_PRESS -> waitingStep=0 and cpuEnable=0 immediately without a clock edge. After release, the FSM is in RUN with the divider restarting from 0.
